// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch stage with a DEPTH-entry prefetch FIFO and a
// request/grant/response instruction-memory interface. Up to DEPTH fetches
// may be in flight. Returned instructions are buffered and handed to decode
// one per non-stalled cycle. A redirect flushes the queue, discards stale
// in-flight responses and presents NOPs (ir = 0) until the new stream
// arrives.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, the stall_cnt and flush_cnt performance counters and
//   their ports are present. When undefined, neither the ports nor the
//   counter logic exist.
//
// Ports
//   clk           in   single clock, all state on rising edge
//   reset         in   asynchronous active-low reset, clears all state
//   load_pc_flag  in   redirect request (branch/jump taken)
//   load_pc       in   redirect target address
//   stall         in   decode cannot accept; pc/ir/ir_valid are held
//   imem_req      out  fetch request valid
//   imem_addr     out  fetch address
//   imem_gnt      in   memory accepts the request this cycle
//   imem_rvalid   in   response valid (in request order)
//   imem_rdata    in   response instruction
//   pc            out  address of ir
//   ir            out  instruction to decode, 0 = NOP
//   ir_valid      out  ir holds a real fetched instruction
//   stall_cnt     out  stalled cycles with ir_valid=1 (FETCH_PERF_CNT_EN)
//   flush_cnt     out  redirects taken (FETCH_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int A_SIZE = 10,
    parameter int I_SIZE = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_pc_flag,
    input  logic [A_SIZE-1:0] load_pc,
    input  logic              stall,
    output logic              imem_req,
    output logic [A_SIZE-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [I_SIZE-1:0] imem_rdata,
    output logic [A_SIZE-1:0] pc,
    output logic [I_SIZE-1:0] ir,
    output logic              ir_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [A_SIZE-1:0] PC_ONE    = A_SIZE'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W:0]    DEPTH_SUM = (CNT_W + 1)'(DEPTH);

    // Architectural state
    logic [A_SIZE-1:0] fetch_pc_r;
    logic [A_SIZE-1:0] resp_pc_r;
    logic [CNT_W-1:0]  outstanding_r;
    logic [CNT_W-1:0]  drop_cnt_r;
    logic [CNT_W-1:0]  count_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [A_SIZE-1:0] fifo_pc_r [DEPTH];
    logic [I_SIZE-1:0] fifo_ir_r [DEPTH];
    logic [A_SIZE-1:0] pc_r;
    logic [I_SIZE-1:0] ir_r;
    logic              ir_valid_r;

    // Next-state helpers
    logic [CNT_W:0]    credit_sum_s;
    logic              req_s;
    logic              grant_s;
    logic              drop_resp_s;
    logic              push_s;
    logic              advance_s;
    logic              pop_s;
    logic [CNT_W-1:0]  outstanding_nxt_s;
    logic [CNT_W-1:0]  redirect_drop_s;

    // Request credit: FIFO entries plus in-flight fetches never exceed DEPTH,
    // so every response has a slot waiting for it. The request is also
    // masked while reset is asserted so nothing is issued from reset state.
    always_comb begin
        credit_sum_s = {1'b0, count_r} + {1'b0, outstanding_r};
        if (reset && !load_pc_flag && (credit_sum_s < DEPTH_SUM)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
    end

    // Handshake qualifiers for grant, response accept/drop and output pop.
    always_comb begin
        grant_s     = req_s && imem_gnt;
        drop_resp_s = imem_rvalid && (drop_cnt_r != CNT_ZERO);
        push_s      = imem_rvalid && (drop_cnt_r == CNT_ZERO) && !load_pc_flag;
        advance_s   = !stall || !ir_valid_r;
        pop_s       = advance_s && (count_r != CNT_ZERO) && !load_pc_flag;
    end

    // Outstanding-request bookkeeping; a grant and a response in the same
    // cycle cancel out.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        case ({grant_s, imem_rvalid})
            2'b10: outstanding_nxt_s = outstanding_r + CNT_ONE;
            2'b01: begin
                if (outstanding_r != CNT_ZERO) begin
                    outstanding_nxt_s = outstanding_r - CNT_ONE;
                end else begin
                    outstanding_nxt_s = outstanding_r;
                end
            end
            default: outstanding_nxt_s = outstanding_r;
        endcase
    end

    // Responses still owed at a redirect are stale; one arriving in the
    // redirect cycle itself is already being discarded, so it is not counted.
    always_comb begin
        if (imem_rvalid && (outstanding_r != CNT_ZERO)) begin
            redirect_drop_s = outstanding_r - CNT_ONE;
        end else if (imem_rvalid) begin
            redirect_drop_s = CNT_ZERO;
        end else begin
            redirect_drop_s = outstanding_r;
        end
    end

    // In-flight request counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding_r <= CNT_ZERO;
        end else begin
            outstanding_r <= outstanding_nxt_s;
        end
    end

    // Fetch/response address tracking and stale-response drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_r <= {A_SIZE{1'b0}};
            resp_pc_r  <= {A_SIZE{1'b0}};
            drop_cnt_r <= CNT_ZERO;
        end else if (load_pc_flag) begin
            fetch_pc_r <= load_pc;
            resp_pc_r  <= load_pc;
            drop_cnt_r <= redirect_drop_s;
        end else begin
            if (grant_s) begin
                fetch_pc_r <= fetch_pc_r + PC_ONE;
            end
            if (drop_resp_s) begin
                drop_cnt_r <= drop_cnt_r - CNT_ONE;
            end
            if (push_s) begin
                resp_pc_r <= resp_pc_r + PC_ONE;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else if (load_pc_flag) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_ONE;
            end
        end
    end

    // FIFO storage of {pc, instruction} pairs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_r[i] <= {A_SIZE{1'b0}};
                fifo_ir_r[i] <= {I_SIZE{1'b0}};
            end
        end else if (push_s) begin
            fifo_pc_r[wr_ptr_r] <= resp_pc_r;
            fifo_ir_r[wr_ptr_r] <= imem_rdata;
        end
    end

    // Decode-facing output registers: redirect beats stall, stall holds a
    // valid instruction, otherwise pop the head or present a NOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r       <= {A_SIZE{1'b0}};
            ir_r       <= {I_SIZE{1'b0}};
            ir_valid_r <= 1'b0;
        end else if (load_pc_flag) begin
            pc_r       <= load_pc;
            ir_r       <= {I_SIZE{1'b0}};
            ir_valid_r <= 1'b0;
        end else if (advance_s) begin
            if (count_r != CNT_ZERO) begin
                pc_r       <= fifo_pc_r[rd_ptr_r];
                ir_r       <= fifo_ir_r[rd_ptr_r];
                ir_valid_r <= 1'b1;
            end else begin
                ir_r       <= {I_SIZE{1'b0}};
                ir_valid_r <= 1'b0;
            end
        end
    end

    assign imem_req  = req_s;
    assign imem_addr = fetch_pc_r;
    assign pc        = pc_r;
    assign ir        = ir_r;
    assign ir_valid  = ir_valid_r;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    // Saturating performance counters for held-valid stalls and redirects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            if (stall && ir_valid_r && !load_pc_flag && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (load_pc_flag && (flush_cnt_r != 16'hFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue with an in-order memory model returning
// rdata = addr + 0x100 after a programmable latency, and a scoreboard that
// tracks the expected decode stream (address sequence, holds, NOPs,
// redirects). Optional FETCH_PERF_CNT_EN counters are checked when defined.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int A_SIZE = 10;
    localparam int I_SIZE = 16;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic              load_pc_flag;
    logic [A_SIZE-1:0] load_pc;
    logic              stall;
    logic              imem_req;
    logic [A_SIZE-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [I_SIZE-1:0] imem_rdata;
    logic [A_SIZE-1:0] pc;
    logic [I_SIZE-1:0] ir;
    logic              ir_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       stall_cnt;
    logic [15:0]       flush_cnt;
`endif

    fetch_queue #(.A_SIZE(A_SIZE), .I_SIZE(I_SIZE), .DEPTH(DEPTH)) dut (
`ifdef FETCH_PERF_CNT_EN
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .clk          (clk),
        .reset        (reset),
        .load_pc_flag (load_pc_flag),
        .load_pc      (load_pc),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .ir           (ir),
        .ir_valid     (ir_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [I_SIZE-1:0] ir_of(input logic [A_SIZE-1:0] a);
        ir_of = {{(I_SIZE-A_SIZE){1'b0}}, a} + 16'h0100;
    endfunction

    // Memory model state
    logic [A_SIZE-1:0] pend_addr [$];
    int                pend_due  [$];
    int                cyc       = 0;
    int                last_due  = -1;
    int                lat       = 1;
    bit                rand_mode = 1'b0;

    // Values sampled on the falling edge of the cycle just finished
    logic              req_neg;
    logic [A_SIZE-1:0] addr_neg;
    logic              flag_c;
    logic [A_SIZE-1:0] load_c;
    logic              stall_c;

    // Scoreboard state
    logic [A_SIZE-1:0] exp_pc    = '0;
    logic [A_SIZE-1:0] hold_pc   = '0;
    bit                model_vld = 1'b0;
    int                delivered = 0;
    int                perf_stall = 0;
    int                perf_flush = 0;

    task automatic step();
        int due;
        int inflight;
        @(negedge clk);
        req_neg  = imem_req;
        addr_neg = imem_addr;
        flag_c   = load_pc_flag;
        load_c   = load_pc;
        stall_c  = stall;
        inflight = pend_addr.size() + (imem_rvalid ? 1 : 0);
        check("inflight_le_depth", 32'(inflight <= DEPTH), 32'd1);
        if (imem_req && imem_gnt) begin
            if (rand_mode) lat = $urandom_range(1, 3);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(imem_addr);
            pend_due.push_back(due);
        end
        @(posedge clk);
        #1;
        cyc++;
        // Scoreboard for the cycle that just ended
        if (flag_c) begin
            check("redir_valid", 32'(ir_valid), 32'd0);
            check("redir_ir", 32'(ir), 32'd0);
            check("redir_pc", 32'(pc), 32'(load_c));
            exp_pc    = load_c;
            hold_pc   = load_c;
            model_vld = 1'b0;
            perf_flush++;
        end else if (stall_c && model_vld) begin
            check("hold_valid", 32'(ir_valid), 32'd1);
            check("hold_pc", 32'(pc), 32'(hold_pc));
            check("hold_ir", 32'(ir), 32'(ir_of(hold_pc)));
            perf_stall++;
        end else if (ir_valid) begin
            check("seq_pc", 32'(pc), 32'(exp_pc));
            check("seq_ir", 32'(ir), 32'(ir_of(exp_pc)));
            hold_pc   = exp_pc;
            exp_pc    = exp_pc + 10'd1;
            model_vld = 1'b1;
            delivered++;
        end else begin
            check("nop_ir", 32'(ir), 32'd0);
            check("nop_pc", 32'(pc), 32'(hold_pc));
            model_vld = 1'b0;
        end
        // Drive this cycle's memory response and grant
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ir_of(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'h0000;
        end
        imem_gnt = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    int base_delivered;

    initial begin
        reset        = 1'b0;
        load_pc_flag = 1'b0;
        load_pc      = 10'h000;
        stall        = 1'b0;
        imem_gnt     = 1'b1;
        imem_rvalid  = 1'b0;
        imem_rdata   = 16'h0000;

        // Reset state
        #2;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_valid", 32'(ir_valid), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        step();
        step();
        reset = 1'b1;

        // First request right after reset release, address 0
        step();
        check("first_req", 32'(req_neg), 32'd1);
        check("first_addr", 32'(addr_neg), 32'd0);
        step();
        step();
        check("first_valid", 32'(ir_valid), 32'd1);
        check("first_ir", 32'(ir), 32'h100);
        check("first_pc", 32'(pc), 32'd0);

        // Advance to pc=3, then stall 5 cycles
        for (int i = 0; i < 3; i++) step();
        check("pre_stall_pc", 32'(pc), 32'd3);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("stall_pc", 32'(pc), 32'd3);
        check("stall_ir", 32'(ir), 32'h103);
        check("stall_credit_full", 32'(req_neg), 32'd0);
        stall = 1'b0;
        step();
        check("resume_ir", 32'(ir), 32'h104);
        for (int i = 0; i < 6; i++) begin
            step();
            check("throughput", 32'(ir_valid), 32'd1);
        end

        // Redirect under latency-3 memory
        lat = 3;
        for (int i = 0; i < 6; i++) step();
        load_pc_flag = 1'b1;
        load_pc      = 10'h200;
        step();
        load_pc_flag = 1'b0;
        step();
        check("redir_req", 32'(req_neg), 32'd1);
        check("redir_addr", 32'(addr_neg), 32'h200);
        step();
        step();
        step();
        check("stale_dropped", 32'(ir_valid), 32'd0);
        step();
        check("redir_first_ir", 32'(ir), 32'h300);
        check("redir_first_pc", 32'(pc), 32'h200);

        // Back-to-back redirects, last wins; then address wrap
        lat = 1;
        for (int i = 0; i < 8; i++) step();
        load_pc_flag = 1'b1;
        load_pc      = 10'h150;
        step();
        load_pc      = 10'h3FE;
        step();
        load_pc_flag = 1'b0;
        step();
        check("b2b_addr", 32'(addr_neg), 32'h3FE);
        step();
        step();
        check("addr_wrap", 32'(addr_neg), 32'h000);
        check("wrap_pc0", 32'(pc), 32'h3FE);
        step();
        check("wrap_pc1", 32'(pc), 32'h3FF);
        step();
        check("pc_wrap", 32'(pc), 32'h000);
        check("pc_wrap_ir", 32'(ir), 32'h100);

        // Random grant, latency 1..3, random stalls and occasional redirects
        rand_mode      = 1'b1;
        base_delivered = delivered;
        for (int i = 0; i < 300; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) begin
                load_pc_flag = 1'b1;
                load_pc      = 10'($urandom_range(0, 1023));
            end else begin
                load_pc_flag = 1'b0;
            end
            step();
        end
        load_pc_flag = 1'b0;
        stall        = 1'b0;
        check("random_progress", 32'(delivered - base_delivered >= 40), 32'd1);

`ifdef FETCH_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 32'(perf_stall));
        check("flush_cnt", 32'(flush_cnt), 32'(perf_flush));
`endif

        // Reset mid-operation clears state immediately
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_pc", 32'(pc), 32'd0);
        check("mid_rst_ir", 32'(ir), 32'd0);
        check("mid_rst_valid", 32'(ir_valid), 32'd0);
        check("mid_rst_addr", 32'(imem_addr), 32'd0);
        check("mid_rst_req", 32'(imem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
